qlen_gen: RTL and testbench

Queue-length expander: consumes one length word (plus optional outer `eot` bits) on `din` and emits a queue of that many elements on `dout`. Each element carries its index, and the innermost `eot` level marks the final element. This is the inverse of the length counter: it regenerates the innermost queue level from a count. It sits in front of per-element processing stages that need an indexed, `eot`-terminated stream.

---
 rtl/qlen_gen.sv | 91 +++++++++
 tb/tb_qlen_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlen_gen.sv
// qlen_gen: queue-length expander.
// Takes one length word (plus optional outer eot bits) on din and emits that
// many indexed elements on dout, marking the final one with eot[0]. Outer eot
// bits from din are attached to the final element only. A zero count is
// acknowledged immediately and produces no output.
// Optional feature: define QLEN_GEN_OUT_REG_EN to drive dout from an output
// register stage (one cycle of latency, no combinational path into dout).
module qlen_gen #(
    parameter int W_CNT   = 16,
    parameter int DIN_LVL = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DIN_LVL+W_CNT-1:0]   i_din_data,
    input  logic                       i_din_valid,
    output logic                       o_din_ready,
    output logic [DIN_LVL+W_CNT:0]     o_dout_data,
    output logic                       o_dout_valid,
    input  logic                       i_dout_ready
);

    logic [W_CNT-1:0]          r_idx;
    logic [W_CNT-1:0]          w_cnt;
    logic [W_CNT-1:0]          w_cnt_m1;
    logic                      w_last;
    logic                      w_cnt_zero;
    logic                      w_gen_valid;
    logic                      w_gen_fire;
    logic [DIN_LVL:0]          w_eot;
    logic [DIN_LVL+W_CNT:0]    w_gen_data;

    // The count is read straight from din; the producer holds it until acked.
    assign w_cnt      = i_din_data[W_CNT-1:0];
    assign w_cnt_m1   = w_cnt - W_CNT'(1);
    assign w_cnt_zero = (w_cnt == '0);
    assign w_last     = (r_idx == w_cnt_m1);

    // Innermost eot marks the final element of the regenerated queue.
    assign w_eot[0] = w_last;

    // Outer eot levels ride along on the final element only.
    generate
        if (DIN_LVL > 0) begin : g_outer_eot
            assign w_eot[DIN_LVL:1] = w_last ? i_din_data[DIN_LVL+W_CNT-1:W_CNT] : '0;
        end
    endgenerate

    assign w_gen_data  = {w_eot, r_idx};
    assign w_gen_valid = i_din_valid && !w_cnt_zero;

`ifdef QLEN_GEN_OUT_REG_EN
    logic                      r_out_valid;
    logic [DIN_LVL+W_CNT:0]    r_out_data;
    logic                      w_load;

    // The output register accepts a new element when empty or being drained.
    assign w_load     = !r_out_valid || i_dout_ready;
    assign w_gen_fire = w_gen_valid && w_load;

    // Output register stage: isolates dout from din and dout ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= w_gen_valid;
            r_out_data  <= w_gen_data;
        end
    end

    assign o_dout_valid = r_out_valid;
    assign o_dout_data  = r_out_data;
`else
    assign w_gen_fire   = w_gen_valid && i_dout_ready;
    assign o_dout_valid = w_gen_valid;
    assign o_dout_data  = w_gen_data;
`endif

    // din is released once the final element is taken, or at once for a zero count.
    assign o_din_ready = (w_gen_fire && w_last) || (i_din_valid && w_cnt_zero);

    // Index of the next element: advance per element, return to 0 after the last.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx <= '0;
        end else if (w_gen_fire) begin
            r_idx <= w_last ? '0 : r_idx + W_CNT'(1);
        end
    end

endmodule

// File: tb/tb_qlen_gen.sv
// tb_qlen_gen: scoreboard bench for qlen_gen with W_CNT=8, DIN_LVL=1.
// A driver issues length words and pushes the elements they should expand to;
// a monitor pops and compares on every dout handshake.
module tb_qlen_gen;

    localparam int W_CNT   = 8;
    localparam int DIN_LVL = 1;

    logic                     i_clk;
    logic                     i_rst;
    logic [DIN_LVL+W_CNT-1:0] i_din_data;
    logic                     i_din_valid;
    logic                     o_din_ready;
    logic [DIN_LVL+W_CNT:0]   o_dout_data;
    logic                     o_dout_valid;
    logic                     i_dout_ready;

    qlen_gen #(.W_CNT(W_CNT), .DIN_LVL(DIN_LVL)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_din_data   (i_din_data),
        .i_din_valid  (i_din_valid),
        .o_din_ready  (o_din_ready),
        .o_dout_data  (o_dout_data),
        .o_dout_valid (o_dout_valid),
        .i_dout_ready (i_dout_ready)
    );

    int errors = 0;
    int checks = 0;
    int hsCount = 0;
    int ackCount = 0;
    int cycle = 0;
    int readyMode = 0;
    logic [DIN_LVL+W_CNT:0] sbQ[$];
    int hsCycle[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Cycle counter used to time-stamp handshakes.
    initial forever begin
        @(posedge i_clk);
        cycle++;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a count expands into indices 0..cnt-1; the final one
    // carries eot[0]=1 and the outer eot, all others carry zeros.
    task automatic pushExpected(input int cnt, input bit eot);
        for (int i = 0; i < cnt; i++) begin
            bit isLast;
            isLast = (i == cnt - 1);
            sbQ.push_back({isLast ? eot : 1'b0, isLast, 8'(i)});
        end
    endtask

    // dout ready pattern: 0 = always, 1 = toggling, 2 = random.
    initial begin
        i_dout_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (readyMode)
                0: i_dout_ready = 1'b1;
                1: i_dout_ready = ~i_dout_ready;
                default: i_dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        bit stallPrev;
        logic [DIN_LVL+W_CNT:0] stallData;
        logic [DIN_LVL+W_CNT:0] exp;
        stallPrev = 0;
        stallData = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                stallPrev = 0;
            end else begin
                if (stallPrev)
                    checkVal("stall_hold", {o_dout_valid, o_dout_data}, {1'b1, stallData});
                if (o_dout_valid && i_dout_ready) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_element: got %0h expected none", o_dout_data);
                    end else begin
                        exp = sbQ.pop_front();
                        checkVal("element", o_dout_data, exp);
                    end
                    hsCount++;
                    hsCycle.push_back(cycle);
                end
                stallPrev = o_dout_valid && !i_dout_ready;
                stallData = o_dout_data;
            end
        end
    end

    // Waits (bounded) for din to be acknowledged; leaves time at posedge+1.
    task automatic waitAck(input int cnt, input int hsBase, input string name);
        bit got;
        got = 0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge i_clk);
            if (o_din_ready && !i_rst) begin
                got = 1;
`ifndef QLEN_GEN_OUT_REG_EN
                if (cnt == 0)
                    checkVal({name, "_zero_noout"}, 32'(o_dout_valid), 32'd0);
                else
                    checkVal({name, "_ack_on_last"}, {29'd0, o_dout_valid, i_dout_ready, o_dout_data[W_CNT]}, 32'd7);
`endif
            end
            @(posedge i_clk);
            #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no din ack expected ack", name);
        end else begin
            ackCount++;
`ifndef QLEN_GEN_OUT_REG_EN
            checkVal({name, "_elems"}, 32'(hsCount - hsBase), 32'(cnt));
`endif
        end
    endtask

    // Issues one length word; din stays valid afterwards until changed by the caller.
    task automatic applyStimulus(input int cnt, input bit eot, input string name, input bit checkLat);
        int hsBase;
        hsBase = hsCount;
        pushExpected(cnt, eot);
        i_din_data  = {eot, 8'(cnt)};
        i_din_valid = 1'b1;
        if (checkLat) begin
            @(negedge i_clk);
`ifdef QLEN_GEN_OUT_REG_EN
            checkVal({name, "_lat_c0"}, 32'(o_dout_valid), 32'd0);
            @(negedge i_clk);
            checkVal({name, "_lat_c1"}, {o_dout_valid, o_dout_data}, {1'b1, 10'h000});
`else
            checkVal({name, "_lat_c0"}, {o_dout_valid, o_dout_data}, {1'b1, 10'h000});
`endif
            checkVal({name, "_no_early_ack"}, 32'(o_din_ready), 32'd0);
        end
        waitAck(cnt, hsBase, name);
    endtask

    task automatic idle();
        i_din_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && sbQ.size() > 0; c++) @(posedge i_clk);
        #1;
        checkVal({name, "_drained"}, 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        int base;
        int b2;
        int startCycle;
        int expAcks;
        i_rst       = 1'b1;
        i_din_valid = 1'b0;
        i_din_data  = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkVal("reset_valid", 32'(o_dout_valid), 32'd0);
        checkVal("reset_idx", 32'(dut.r_idx), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        expAcks = 0;

        $display("[TB] basic queue");
        applyStimulus(3, 1'b1, "basic", 1'b1);
        expAcks++;
        idle();
        drain("basic");

        $display("[TB] zero count");
        applyStimulus(0, 1'b1, "zero", 1'b0);
        applyStimulus(1, 1'b0, "after_zero", 1'b0);
        expAcks += 2;
        idle();
        drain("zero");

        $display("[TB] backpressure");
        readyMode = 1;
        applyStimulus(4, 1'b0, "bp", 1'b0);
        expAcks++;
        idle();
        drain("bp");
        readyMode = 0;
        repeat (2) @(posedge i_clk);
        #1;

        $display("[TB] max count");
        applyStimulus(255, 1'b1, "max", 1'b0);
        expAcks++;
        checkVal("max_idx_back_to_0", 32'(dut.r_idx), 32'd0);
        idle();
        drain("max");

        $display("[TB] reset mid-queue");
        base = hsCount;
        pushExpected(5, 1'b0);
        i_din_data  = {1'b0, 8'd5};
        i_din_valid = 1'b1;
        for (int c = 0; c < 50 && hsCount < base + 2; c++) begin
            @(posedge i_clk);
            #1;
        end
        checkVal("rst_two_before", 32'(hsCount - base), 32'd2);
        i_rst = 1'b1;
        sbQ.delete();
        pushExpected(5, 1'b0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        b2 = hsCount;
        waitAck(5, b2, "rst_mid");
        expAcks++;
        idle();
        drain("rst_mid");

        $display("[TB] back-to-back");
        repeat (3) @(posedge i_clk);
        #1;
        base = hsCycle.size();
        startCycle = cycle;
        applyStimulus(2, 1'b0, "b2b_a", 1'b0);
        applyStimulus(3, 1'b1, "b2b_b", 1'b0);
        expAcks += 2;
        idle();
        drain("b2b");
        if (hsCycle.size() >= base + 5) begin
`ifdef QLEN_GEN_OUT_REG_EN
            checkVal("b2b_first_cycle", 32'(hsCycle[base] - startCycle), 32'd1);
`else
            checkVal("b2b_first_cycle", 32'(hsCycle[base] - startCycle), 32'd0);
`endif
            checkVal("b2b_no_bubble", 32'(hsCycle[base+4] - hsCycle[base]), 32'd4);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 5", hsCycle.size() - base);
        end

        $display("[TB] random queues");
        for (int q = 0; q < 40; q++) begin
            readyMode = int'($urandom_range(0, 2));
            applyStimulus(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), "rnd", 1'b0);
            expAcks++;
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat (int'($urandom_range(1, 3))) @(posedge i_clk);
                #1;
            end
        end
        idle();
        readyMode = 0;
        drain("final");
        repeat (3) @(posedge i_clk);
        #1;
        checkVal("ack_total", 32'(ackCount), 32'(expAcks));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
